segment_step_sequencer: RTL and testbench

Controller between the motion-segment FIFO and the step output pin. It pops 32-bit motion-segment records from the FIFO's show-ahead head and sequences a programmed number of fixed-width step pulses at the period each record gives. Back-to-back segments chain with no gap. It reports busy, segment-done and underrun status to the host-facing logic.

---
 rtl/beagleg_pkg.sv | 32 +++
 rtl/segment_step_sequencer_if.sv | 21 ++
 rtl/step_pulse_timer.sv | 55 +++++
 rtl/segment_step_sequencer.sv | 145 ++++++++++++++
 tb/tb_segment_step_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/beagleg_pkg.sv
// Shared motion-segment record layout and sequencer state encoding.
// Also used by the segment FIFO and the SPI command decoder.
package beagleg_pkg;

   localparam int unsigned RecordBits    = 32;
   localparam int unsigned SegStepsBits  = 16;
   localparam int unsigned SegStepsLsb   = 16;
   localparam int unsigned SegPeriodBits = 16;
   localparam int unsigned SegPeriodLsb  = 0;

   typedef struct packed {
      logic [SegStepsBits-1:0]  steps;
      logic [SegPeriodBits-1:0] period;
   } motion_segment_t;

   typedef enum logic [1:0] {
      StIdle,
      StStepHigh,
      StStepLow
   } seq_state_e;

   // A period must leave at least one low cycle after the high phase.
   function automatic logic [SegPeriodBits-1:0] eff_period(
      input logic [SegPeriodBits-1:0] period,
      input int unsigned              pulse_width
   );
      logic [SegPeriodBits-1:0] floor_p;
      floor_p = SegPeriodBits'(pulse_width + 1);
      return (period < floor_p) ? floor_p : period;
   endfunction

endpackage

// File: rtl/segment_step_sequencer_if.sv
// Show-ahead FIFO head plus pop strobe between segment FIFO and sequencer.
interface segment_step_sequencer_if;
   import beagleg_pkg::*;

   motion_segment_t fifo_record;
   logic            fifo_empty;
   logic            fifo_pop;

   modport master (
      input  fifo_record,
      input  fifo_empty,
      output fifo_pop
   );

   modport slave (
      output fifo_record,
      output fifo_empty,
      input  fifo_pop
   );

endinterface

// File: rtl/step_pulse_timer.sv
// Single period counter: flags the high phase of a step pulse and strobes the
// last cycle of each period. A start in the period_end cycle chains seamlessly.
module step_pulse_timer #(
   parameter int unsigned PERIOD_BITS = 16,
   parameter int unsigned PULSE_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   start,
   input  logic [PERIOD_BITS-1:0] eff_period,
   output logic                   high,
   output logic                   period_end
);

   logic                   active_q, active_d;
   logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
   logic [PERIOD_BITS-1:0] period_q, period_d;

   always_comb begin
      high       = active_q && (cnt_q < PERIOD_BITS'(PULSE_WIDTH));
      period_end = active_q && (cnt_q == period_q - PERIOD_BITS'(1));

      active_d = active_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      if (clear) begin
         active_d = 1'b0;
         cnt_d    = '0;
         period_d = '0;
      end else if (start) begin
         active_d = 1'b1;
         cnt_d    = '0;
         period_d = eff_period;
      end else if (period_end) begin
         active_d = 1'b0;
         cnt_d    = '0;
      end else if (active_q) begin
         cnt_d = cnt_q + PERIOD_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         period_q <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
      end
   end

endmodule

// File: rtl/segment_step_sequencer.sv
// Pops motion-segment records and emits the programmed number of step pulses
// at each record's period, chaining back-to-back segments without a gap.
module segment_step_sequencer
   import beagleg_pkg::*;
#(
   parameter int unsigned STEP_COUNT_BITS = SegStepsBits,
   parameter int unsigned PERIOD_BITS     = SegPeriodBits,
   parameter int unsigned PULSE_WIDTH     = 4,
   parameter int unsigned UNDERRUN_BITS   = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         abort,
   segment_step_sequencer_if.master     fifo,
   output logic                         step_out,
   output logic                         busy,
   output logic                         segment_done,
   output logic [UNDERRUN_BITS-1:0]     underrun_count
);

   seq_state_e                 state_q, state_d;
   logic [STEP_COUNT_BITS-1:0] steps_q, steps_d;
   logic [PERIOD_BITS-1:0]     period_q, period_d;
   logic                       waiting_q, waiting_d;
   logic                       zero_pend_q, zero_pend_d;
   logic                       done_q, done_d;
   logic [UNDERRUN_BITS-1:0]   under_q, under_d;

   motion_segment_t            head;
   logic [STEP_COUNT_BITS-1:0] head_steps;
   logic [PERIOD_BITS-1:0]     head_period;
   logic                       running, seg_end, load, complete;
   logic                       tmr_start, tmr_high, tmr_period_end;
   logic [PERIOD_BITS-1:0]     tmr_period;

   assign head        = fifo.fifo_record;
   assign head_steps  = STEP_COUNT_BITS'(head.steps);
   assign head_period = PERIOD_BITS'(eff_period(head.period, PULSE_WIDTH));

   always_comb begin
      running  = (state_q != StIdle);
      seg_end  = running && tmr_period_end && (steps_q == STEP_COUNT_BITS'(1));
      load     = enable && !fifo.fifo_empty && !abort && !reset &&
                 ((state_q == StIdle) || seg_end);
      // A zero-step record completes the cycle after it was latched.
      complete = !abort && (seg_end || zero_pend_q);

      state_d     = state_q;
      steps_d     = steps_q;
      period_d    = period_q;
      waiting_d   = waiting_q;
      zero_pend_d = 1'b0;
      done_d      = complete;
      under_d     = under_q;
      tmr_start   = 1'b0;

      if (complete && enable && fifo.fifo_empty && (under_q != '1)) begin
         under_d = under_q + UNDERRUN_BITS'(1);
      end

      if (abort) begin
         state_d   = StIdle;
         steps_d   = '0;
         waiting_d = 1'b0;
      end else begin
         if (running && tmr_period_end) begin
            if (seg_end) begin
               state_d = StIdle;
               steps_d = '0;
            end else begin
               steps_d = steps_q - STEP_COUNT_BITS'(1);
               if (enable) begin
                  tmr_start = 1'b1;
                  state_d   = StStepHigh;
               end else begin
                  waiting_d = 1'b1;
                  state_d   = StStepLow;
               end
            end
         end else if (waiting_q && enable) begin
            tmr_start = 1'b1;
            waiting_d = 1'b0;
            state_d   = StStepHigh;
         end else if ((state_q == StStepHigh) && !tmr_high) begin
            state_d = StStepLow;
         end

         if (load) begin
            steps_d   = head_steps;
            period_d  = head_period;
            waiting_d = 1'b0;
            if (head_steps == '0) begin
               zero_pend_d = 1'b1;
               state_d     = StIdle;
            end else begin
               tmr_start = 1'b1;
               state_d   = StStepHigh;
            end
         end
      end
   end

   assign tmr_period = load ? head_period : period_q;

   step_pulse_timer #(
      .PERIOD_BITS (PERIOD_BITS),
      .PULSE_WIDTH (PULSE_WIDTH)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .clear      (abort),
      .start      (tmr_start),
      .eff_period (tmr_period),
      .high       (tmr_high),
      .period_end (tmr_period_end)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         steps_q     <= '0;
         period_q    <= '0;
         waiting_q   <= 1'b0;
         zero_pend_q <= 1'b0;
         done_q      <= 1'b0;
         under_q     <= '0;
      end else begin
         state_q     <= state_d;
         steps_q     <= steps_d;
         period_q    <= period_d;
         waiting_q   <= waiting_d;
         zero_pend_q <= zero_pend_d;
         done_q      <= done_d;
         under_q     <= under_d;
      end
   end

   assign fifo.fifo_pop  = load;
   assign step_out       = tmr_high;
   assign busy           = running;
   assign segment_done   = done_q;
   assign underrun_count = under_q;

endmodule

// File: tb/tb_segment_step_sequencer.sv
// Bench for segment_step_sequencer: a pulse-schedule model in absolute cycle
// times is checked every cycle, plus literal timing pins for directed cases.
module tb_segment_step_sequencer;
   import beagleg_pkg::*;

   localparam int PW = 4;

   logic       clk = 1'b0;
   logic       reset, enable, abort;
   logic       step_out, busy, segment_done;
   logic [7:0] underrun_count;

   segment_step_sequencer_if fifo_if ();

   segment_step_sequencer #(
      .STEP_COUNT_BITS (16),
      .PERIOD_BITS     (16),
      .PULSE_WIDTH     (PW),
      .UNDERRUN_BITS   (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .abort          (abort),
      .fifo           (fifo_if.master),
      .step_out       (step_out),
      .busy           (busy),
      .segment_done   (segment_done),
      .underrun_count (underrun_count)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0, cyc = 0;
   logic [31:0] fq[$];
   bit en_v, ab_v, rst_v;

   // Model: a loaded segment is a train of rising edges at m_rise + k*m_period.
   bit m_active, m_waiting, m_zero, m_done;
   int m_rise, m_steps, m_period, m_under;

   int pop_log[$], rise_log[$], done_log[$];
   int busy_cycles;
   bit prev_step;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   task automatic model_reset();
      m_active = 0; m_waiting = 0; m_zero = 0; m_done = 0;
      m_rise = 0; m_steps = 0; m_period = 0; m_under = 0;
   endtask

   task automatic clear_logs();
      pop_log.delete(); rise_log.delete(); done_log.delete();
      busy_cycles = 0;
   endtask

   task automatic tick();
      bit m_step, m_pend, m_last, m_pop, empty, complete;
      logic [31:0] head;
      int st, pr;
      @(negedge clk);
      reset  = rst_v;
      enable = en_v;
      abort  = ab_v;
      empty  = (fq.size() == 0);
      head   = empty ? 32'h0 : fq[0];
      fifo_if.fifo_empty  = empty;
      fifo_if.fifo_record = head;
      #1;
      m_step = m_active && !m_waiting && ((cyc - m_rise) < PW);
      m_pend = m_active && !m_waiting && ((cyc - m_rise) == m_period - 1);
      m_last = m_pend && (m_steps == 1);
      m_pop  = !rst_v && en_v && !empty && !ab_v && (!m_active || m_last);
      chk("step_out", step_out, m_step);
      chk("busy", busy, m_active);
      chk("segment_done", segment_done, m_done);
      chk("underrun_count", underrun_count, m_under);
      chk("fifo_pop", fifo_if.fifo_pop, m_pop);

      if (fifo_if.fifo_pop === 1'b1) pop_log.push_back(cyc);
      if (step_out === 1'b1 && !prev_step) rise_log.push_back(cyc);
      prev_step = (step_out === 1'b1);
      if (segment_done === 1'b1) done_log.push_back(cyc);
      if (busy === 1'b1) busy_cycles++;

      if (rst_v) begin
         model_reset();
      end else if (ab_v) begin
         m_active = 0; m_waiting = 0; m_zero = 0; m_done = 0; m_steps = 0;
      end else begin
         complete = m_last || m_zero;
         m_done   = complete;
         m_zero   = 0;
         if (complete && en_v && empty && m_under < 255) m_under++;
         if (m_pend && !m_last) begin
            m_steps--;
            if (en_v) m_rise = cyc + 1;
            else m_waiting = 1;
         end else if (m_waiting && en_v) begin
            m_waiting = 0;
            m_rise = cyc + 1;
         end
         if (m_last) m_active = 0;
         if (m_pop) begin
            st = int'(head[31:16]);
            pr = int'(head[15:0]);
            if (pr < PW + 1) pr = PW + 1;
            m_steps = st; m_period = pr; m_waiting = 0;
            if (st == 0) m_zero = 1;
            else begin
               m_active = 1;
               m_rise = cyc + 1;
            end
         end
      end
      if (m_pop) void'(fq.pop_front());
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      fq.delete();
      rst_v = 1; en_v = 0; ab_v = 0;
      run(2);
      rst_v = 0;
      clear_logs();
   endtask

   function automatic logic [31:0] rec(input int steps, input int period);
      return {16'(steps), 16'(period)};
   endfunction

   initial begin
      int p;
      reset = 1; enable = 0; abort = 0;
      fifo_if.fifo_empty = 1; fifo_if.fifo_record = '0;
      repeat (2) @(posedge clk);
      model_reset();
      prev_step = 0;

      // Reset state and a plain three-step segment.
      do_reset();
      chk("reset_busy", busy, 0);
      chk("reset_step", step_out, 0);
      chk("reset_underrun", underrun_count, 0);
      fq.push_back(rec(3, 10)); en_v = 1;
      run(40);
      chk("s1_pops", pop_log.size(), 1);
      chk("s1_rises", rise_log.size(), 3);
      chk("s1_rise0", at(rise_log, 0) - at(pop_log, 0), 1);
      chk("s1_rise1", at(rise_log, 1) - at(pop_log, 0), 11);
      chk("s1_rise2", at(rise_log, 2) - at(pop_log, 0), 21);
      chk("s1_done", at(done_log, 0) - at(pop_log, 0), 31);
      chk("s1_busy_cycles", busy_cycles, 30);
      chk("s1_underrun", underrun_count, 1);

      // Two chained segments.
      do_reset();
      fq.push_back(rec(2, 8)); fq.push_back(rec(1, 12)); en_v = 1;
      run(45);
      chk("s2_pop1", at(pop_log, 1) - at(pop_log, 0), 16);
      chk("s2_rise1", at(rise_log, 1) - at(pop_log, 0), 9);
      chk("s2_rise2", at(rise_log, 2) - at(pop_log, 0), 17);
      chk("s2_dones", done_log.size(), 2);
      chk("s2_underrun", underrun_count, 1);

      // Period clamp, then a zero-step record.
      do_reset();
      fq.push_back(rec(2, 2)); en_v = 1;
      run(20);
      chk("s3_rise_gap", at(rise_log, 1) - at(rise_log, 0), 5);
      chk("s3_done", at(done_log, 0) - at(pop_log, 0), 11);
      do_reset();
      fq.push_back(rec(0, 100)); en_v = 1;
      run(10);
      chk("s3_zero_rises", rise_log.size(), 0);
      chk("s3_zero_done", at(done_log, 0) - at(pop_log, 0), 2);

      // Enable dropped during pulse 2, then resumed.
      do_reset();
      fq.push_back(rec(4, 10)); en_v = 1;
      tick();
      p = at(pop_log, 0);
      run(12);
      en_v = 0;
      run(20);
      chk("s4_hold_busy", busy, 1);
      chk("s4_hold_step", step_out, 0);
      en_v = 1;
      run(40);
      chk("s4_rises", rise_log.size(), 4);
      chk("s4_rise2", at(rise_log, 2) - p, 34);
      chk("s4_done", at(done_log, 0) - p, 54);

      // Abort in the second high cycle with the FIFO still holding a record.
      do_reset();
      fq.push_back(rec(3, 10)); fq.push_back(rec(2, 6)); en_v = 1;
      tick();
      p = at(pop_log, 0);
      tick();
      ab_v = 1; tick(); ab_v = 0;
      tick();
      chk("s5_step_after_abort", step_out, 0);
      chk("s5_busy_after_abort", busy, 0);
      run(30);
      chk("s5_pops", pop_log.size(), 2);
      chk("s5_pop_resume", at(pop_log, 1) - p, 3);
      chk("s5_dones", done_log.size(), 1);
      chk("s5_done", at(done_log, 0) - p, 16);

      // Underrun saturation.
      do_reset();
      en_v = 1;
      for (int i = 0; i < 300; i++) begin
         fq.push_back(rec(1, 5));
         run(8);
      end
      chk("s6_underrun_sat", underrun_count, 255);

      // Reset in the middle of a pulse.
      do_reset();
      fq.push_back(rec(5, 10)); en_v = 1;
      run(2);
      rst_v = 1; tick(); rst_v = 0;
      tick();
      chk("s6_rst_step", step_out, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_done", segment_done, 0);
      chk("s6_rst_underrun", underrun_count, 0);

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         en_v  = ($urandom_range(9) != 0);
         ab_v  = ($urandom_range(59) == 0);
         rst_v = ($urandom_range(499) == 0);
         if (fq.size() < 3 && $urandom_range(3) == 0)
            fq.push_back(rec($urandom_range(4), $urandom_range(13)));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
